mac_stream_acc: RTL and testbench

- Stream-side consumer for the 4-lane MAC datapath.
- Accepts a job of `len` beats. Each beat carries four unsigned activations and four signed weights, transferred over a valid/ready handshake.
- Accumulates `sum(a_i*b_i)` over all beats into one psum and presents the result on a valid/ready output.
- Sits between the activation/weight SRAM readers and the psum writer in the PE tile.

---
 rtl/mac_stream_acc.sv | 125 ++++++++++++
 tb/tb_mac_stream_acc.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mac_stream_acc.sv
// mac_stream_acc: stream-side consumer for the 4-lane MAC datapath.
// Accepts a job of `len` beats over a valid/ready handshake. Each beat carries
// four unsigned activations and four signed weights. The block accumulates
// sum(a_i*b_i) over all beats into one psum and presents it on valid/ready.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   start      pulse; begins a job when idle
//   len        beats in job, sampled when start is accepted
//   in_valid   beat available
//   in_ready   block can accept a beat (RUN only)
//   a_in       lanes a0..a3, a0 in LSBs, unsigned
//   b_in       lanes b0..b3, b0 in LSBs, two's complement
//   out_valid  result available
//   out_ready  downstream accepts result
//   out        accumulated psum (wraps modulo 2^psum_bw)
//   busy       high in any state except IDLE
module mac_stream_acc #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int len_bw  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [len_bw-1:0]    len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*bw-1:0]      a_in,
  input  logic [4*bw-1:0]      b_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [psum_bw-1:0]   out,
  output logic                 busy
);

  localparam int prod_w = 2*bw + 1;
  localparam int sum_w  = 2*bw + 3;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t               state, state_nxt;
  logic [len_bw-1:0]    cnt;
  logic [sum_w-1:0]     p_reg;
  logic                 p_vld;
  logic [psum_bw-1:0]   acc;
  logic [psum_bw-1:0]   out_q;
  logic                 out_vld_q;

  logic                 xfer;
  logic                 ack;
  logic [sum_w-1:0]     lane_sum;
  logic [prod_w-1:0]    a_ext, b_ext, prod;

  assign xfer      = in_valid && in_ready;
  assign ack       = out_vld_q && out_ready;
  assign out_valid = out_vld_q;
  assign out       = out_q;

  // Lane products computed modulo 2^prod_w: a zero-extended, b sign-extended,
  // so the low prod_w bits of the unsigned product are the signed product.
  always_comb begin
    lane_sum = '0;
    a_ext    = '0;
    b_ext    = '0;
    prod     = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      a_ext    = {{bw{1'b0}}, a_in[i*bw +: bw]};
      b_ext    = {{(bw+1){b_in[i*bw + bw - 1]}}, b_in[i*bw +: bw]};
      prod     = a_ext * b_ext;
      lane_sum = lane_sum + {{(sum_w-prod_w){prod[prod_w-1]}}, prod};
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      IDLE:  if (start) state_nxt = (len == '0) ? DONE : RUN;
      RUN: begin
        in_ready = 1'b1;
        if (xfer && cnt == len_bw'(1)) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = DONE;
      DONE:  if (ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      p_reg     <= '0;
      p_vld     <= 1'b0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      state <= state_nxt;
      p_vld <= xfer;
      if (xfer) p_reg <= lane_sum;

      if (state == IDLE && start) begin
        cnt <= len;
        acc <= '0;
      end else begin
        if (xfer)  cnt <= cnt - len_bw'(1);
        if (p_vld) acc <= acc + {{(psum_bw-sum_w){p_reg[sum_w-1]}}, p_reg};
      end

      // out_valid is registered: it rises on the edge after entering DONE,
      // when acc has settled, and out is captured from acc on that same edge.
      if (state == DONE && !out_vld_q) begin
        out_vld_q <= 1'b1;
        out_q     <= acc;
      end else if (ack) begin
        out_vld_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_stream_acc.sv
module tb_mac_stream_acc;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int rdy_bad = 0;
  bit zero_job = 0;

  logic [15:0] a_arr [256];
  logic [15:0] b_arr [256];

  mac_stream_acc #(.bw(4), .psum_bw(16), .len_bw(8)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // in_ready must never coincide with a pending result or a zero-length job
  always @(negedge clk)
    if (!reset && in_ready && (out_valid || zero_job)) rdy_bad++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] beat_sum(input logic [15:0] a, input logic [15:0] b);
    int s = 0;
    for (int i = 0; i < 4; i++) begin
      int av = int'(a[4*i +: 4]);
      int bv = int'(b[4*i +: 4]);
      if (bv > 7) bv = bv - 16;
      s = s + av * bv;
    end
    return s[15:0];
  endfunction

  function automatic logic [15:0] job_sum(input int n);
    logic [15:0] c = '0;
    for (int i = 0; i < n; i++) c = c + beat_sum(a_arr[i], b_arr[i]);
    return c;
  endfunction

  task automatic run_job(input string tag, input int n, input bit gappy,
                         input int hold, input logic [15:0] exp_out);
    int idx = 0;
    int budget = 0;
    int lat = 0;
    bit xfer;
    logic [15:0] held;
    check({tag, "_idle_rdy"}, 32'(in_ready), 32'd0);
    start = 1'b1;
    len   = n[7:0];
    tick();
    start = 1'b0;
    while (idx < n && budget < 2000) begin
      in_valid = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
      a_in = a_arr[idx];
      b_in = b_arr[idx];
      xfer = in_valid && in_ready;
      tick();
      budget++;
      if (xfer) idx++;
    end
    in_valid = 1'b0;
    if (idx != n) check({tag, "_beat_timeout"}, idx, n);
    if (n > 0) check({tag, "_drain_rdy"}, 32'(in_ready), 32'd0);
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, (n == 0) ? 1 : 2);
    check({tag, "_out"}, 32'(out), 32'(exp_out));
    held = out;
    for (int h = 0; h < hold; h++) begin
      start = (h == 0);
      tick();
      start = 1'b0;
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_out"}, 32'(out), 32'(held));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_post_busy"}, 32'(busy), 32'd0);
    check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_post_out"}, 32'(out), 32'(held));
  endtask

  initial begin
    logic [15:0] exp_rand;
    reset = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
    a_in = '0; b_in = '0; out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    reset = 1'b0;
    tick();

    // single beat: 1+2+3+4
    a_arr[0] = 16'h4321; b_arr[0] = 16'h1111;
    run_job("single", 1, 1'b0, 0, 16'h000A);

    // negative extremes: 4 * 15 * -8 = -480
    a_arr[0] = 16'hFFFF; b_arr[0] = 16'h8888;
    run_job("negext", 1, 1'b0, 0, 16'hFE20);

    // 200 * -480 = -96000 wraps to 0x8900
    for (int i = 0; i < 200; i++) begin
      a_arr[i] = 16'hFFFF; b_arr[i] = 16'h8888;
    end
    run_job("wrap", 200, 1'b0, 0, 16'h8900);

    // random 10-beat job, then the same beats with in_valid gaps
    for (int i = 0; i < 10; i++) begin
      a_arr[i] = 16'($urandom);
      b_arr[i] = 16'($urandom);
    end
    exp_rand = job_sum(10);
    run_job("rand", 10, 1'b0, 5, exp_rand);
    run_job("rand_gap", 10, 1'b1, 0, exp_rand);

    // zero-length job
    zero_job = 1'b1;
    run_job("len0", 0, 1'b0, 0, 16'h0000);
    zero_job = 1'b0;

    // reset after 3 of 6 beats
    start = 1'b1; len = 8'd6;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a_in = 16'hFFFF; b_in = 16'h7777;
      tick();
    end
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_out", 32'(out), 32'd0);
    reset = 1'b0;
    tick();
    a_arr[0] = 16'h0002; b_arr[0] = 16'h0003;
    run_job("after_abort", 1, 1'b0, 0, 16'h0006);

    check("in_ready_outside_run", rdy_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
